// File: rtl/codificador_jogo.sv
// Role encoder: turns explicit wolf/doctor choices into the packed role word and its seed-ROM address.
// Optional SEED_ADDR_EN builds the seed address path; otherwise seed_addr is tied to 0.
module codificador_jogo #(
  parameter int N_JOG  = 5,
  parameter int ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  iniciar,
  input  logic [2:0]            lobo,
  input  logic [2:0]            medico,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  erro,
  output logic [2*N_JOG-1:0]    jogo,
  output logic [ADDR_W-1:0]     seed_addr,
  output logic [2:0]            db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    VALIDA  = 3'd1,
    MONTA   = 3'd2,
    CONCLUI = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  localparam logic [2:0] ULTIMO_JOG = 3'(N_JOG - 1);

  estado_t              estado;
  logic [2:0]           lobo_reg;
  logic [2:0]           medico_reg;
  logic [2:0]           cnt;
  // Holds only the N_JOG-1 players already shifted; the last class is merged when jogo loads.
  logic [2*N_JOG-3:0]   shift;
  logic [1:0]           classe;
  logic                 ultimo;

  always_comb begin
    classe = 2'b00;
    if (cnt == lobo_reg)
      classe = 2'b01;
    else if (cnt == medico_reg)
      classe = 2'b10;
  end

  assign ultimo    = (cnt == ULTIMO_JOG);
  assign ocupado   = (estado != OCIOSO);
  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= OCIOSO;
      lobo_reg   <= '0;
      medico_reg <= '0;
      cnt        <= '0;
      shift      <= '0;
      jogo       <= '0;
      pronto     <= 1'b0;
      erro       <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          pronto <= 1'b0;
          if (iniciar) begin
            lobo_reg   <= lobo;
            medico_reg <= medico;
            erro       <= 1'b0;
            estado     <= VALIDA;
          end
        end
        VALIDA: begin
          if (int'(lobo_reg) >= N_JOG || int'(medico_reg) >= N_JOG ||
              lobo_reg == medico_reg) begin
            estado <= ERRO;
          end else begin
            shift  <= '0;
            cnt    <= '0;
            estado <= MONTA;
          end
        end
        MONTA: begin
          shift <= {shift[2*N_JOG-5:0], classe};
          cnt   <= cnt + 3'd1;
          if (ultimo) begin
            jogo   <= {shift, classe};
            pronto <= 1'b1;
            estado <= CONCLUI;
          end
        end
        CONCLUI: begin
          pronto <= 1'b0;
          estado <= OCIOSO;
        end
        ERRO: begin
          erro   <= 1'b1;
          estado <= OCIOSO;
        end
        default: begin
          pronto <= 1'b0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

`ifdef SEED_ADDR_EN
  logic [ADDR_W-1:0] addr_calc;

  // Row = wolf index, column = doctor index with the diagonal removed.
  always_comb begin
    addr_calc = ADDR_W'(lobo_reg) * ADDR_W'(N_JOG - 1);
    if (medico_reg < lobo_reg)
      addr_calc = addr_calc + ADDR_W'(medico_reg);
    else
      addr_calc = addr_calc + ADDR_W'(medico_reg) - ADDR_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      seed_addr <= '0;
    else if (estado == MONTA && ultimo)
      seed_addr <= addr_calc;
  end
`else
  assign seed_addr = '0;
`endif

endmodule

// File: tb/tb_codificador_jogo.sv
// Directed self-checking bench for codificador_jogo (N_JOG=5, ADDR_W=5), valid with or without SEED_ADDR_EN.
`timescale 1ns/1ps
module tb_codificador_jogo;

  logic        clock;
  logic        reset_n;
  logic        iniciar;
  logic [2:0]  lobo;
  logic [2:0]  medico;
  logic        ocupado;
  logic        pronto;
  logic        erro;
  logic [9:0]  jogo;
  logic [4:0]  seed_addr;
  logic [2:0]  db_estado;

  int errors = 0;
  int checks = 0;

  codificador_jogo #(.N_JOG(5), .ADDR_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .iniciar   (iniciar),
    .lobo      (lobo),
    .medico    (medico),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .erro      (erro),
    .jogo      (jogo),
    .seed_addr (seed_addr),
    .db_estado (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] exp_addr(input logic [4:0] a);
`ifdef SEED_ADDR_EN
    return a;
`else
    return 5'd0;
`endif
  endfunction

  // Presents a request for one edge; returns half a cycle after the sampling edge.
  task automatic do_start(input logic [2:0] l, input logic [2:0] m);
    @(negedge clock);
    lobo    = l;
    medico  = m;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    iniciar = 1'b0;
    lobo    = '0;
    medico  = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({ocupado, pronto, erro, jogo, seed_addr, db_estado} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got oc=%b pr=%b er=%b jogo=%h addr=%0d st=%0d, want all 0",
               ocupado, pronto, erro, jogo, seed_addr, db_estado);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_encode(input logic [2:0] l, input logic [2:0] m,
                             input logic [9:0] ej, input logic [4:0] ea);
    int n;
    int first;
    int highs;
    do_start(l, m);
    first = 0;
    highs = 0;
    for (n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clock);
      if (pronto) begin
        highs++;
        if (first == 0) first = n;
      end
    end
    checks++;
    if (first != 7 || highs != 1) begin
      errors++;
      $display("FAIL encode_latency l=%0d m=%0d: got first=%0d highs=%0d, want first=7 highs=1",
               l, m, first, highs);
    end
    checks++;
    if (jogo !== ej) begin
      errors++;
      $display("FAIL encode_jogo l=%0d m=%0d: got %h want %h", l, m, jogo, ej);
    end
    checks++;
    if (seed_addr !== exp_addr(ea)) begin
      errors++;
      $display("FAIL encode_addr l=%0d m=%0d: got %0d want %0d", l, m, seed_addr, exp_addr(ea));
    end
  endtask

  task automatic test_error(input logic [2:0] l, input logic [2:0] m,
                            input logic [9:0] prev_j, input logic [4:0] prev_a);
    int n;
    int highs;
    do_start(l, m);
    highs = 0;
    for (n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clock);
      if (pronto) highs++;
    end
    checks++;
    if (erro !== 1'b1 || highs != 0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL error_flag l=%0d m=%0d: got erro=%b pronto_highs=%0d ocupado=%b, want 1 0 0",
               l, m, erro, highs, ocupado);
    end
    checks++;
    if (jogo !== prev_j || seed_addr !== prev_a) begin
      errors++;
      $display("FAIL error_hold l=%0d m=%0d: got jogo=%h addr=%0d want jogo=%h addr=%0d",
               l, m, jogo, seed_addr, prev_j, prev_a);
    end
  endtask

  task automatic test_error_clear;
    do_start(3'd4, 3'd3);
    checks++;
    if (erro !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got erro=%b want 0", erro);
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_ignore_busy;
    int n;
    int busy;
    int first;
    do_start(3'd2, 3'd3);
    busy  = 0;
    first = 0;
    for (n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clock);
      if (n == 2) begin
        lobo    = 3'd4;
        medico  = 3'd3;
        iniciar = 1'b1;
      end else begin
        iniciar = 1'b0;
      end
      if (ocupado) busy++;
      if (pronto && first == 0) first = n;
    end
    checks++;
    if (busy != 7) begin
      errors++;
      $display("FAIL busy_cycles: got %0d want 7", busy);
    end
    checks++;
    if (first != 7 || jogo !== 10'h018 || seed_addr !== exp_addr(5'd10)) begin
      errors++;
      $display("FAIL busy_ignore: got first=%0d jogo=%h addr=%0d want 7 018 %0d",
               first, jogo, seed_addr, exp_addr(5'd10));
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int highs;
    do_start(3'd1, 3'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (db_estado !== 3'd2) begin
      errors++;
      $display("FAIL mid_state: got %0d want 2", db_estado);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ocupado, pronto, erro, jogo, seed_addr, db_estado} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset: got oc=%b pr=%b er=%b jogo=%h addr=%0d st=%0d, want all 0",
               ocupado, pronto, erro, jogo, seed_addr, db_estado);
    end
    @(negedge clock);
    reset_n = 1'b1;
    highs = 0;
    for (n = 0; n < 10; n++) begin
      @(negedge clock);
      if (pronto || ocupado) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL mid_no_pronto: got %0d active cycles want 0", highs);
    end
  endtask

  initial begin
    test_reset();
    test_encode(3'd0, 3'd1, 10'h180, 5'd0);
    test_encode(3'd2, 3'd3, 10'h018, 5'd10);
    test_encode(3'd4, 3'd3, 10'h009, 5'd19);
    test_encode(3'd1, 3'd0, 10'h240, 5'd4);
    test_error(3'd2, 3'd2, 10'h240, exp_addr(5'd4));
    test_error(3'd5, 3'd0, 10'h240, exp_addr(5'd4));
    test_error(3'd0, 3'd7, 10'h240, exp_addr(5'd4));
    test_error_clear();
    test_ignore_busy();
    test_encode(3'd3, 3'd4, 10'h006, 5'd15);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
